trace_capture_ctrl: RTL and testbench
=====================================

// Module: trace_capture_ctrl
// PURPOSE
//  Capture controller for the scope trace path. Decimates the 12-bit ADC stream, detects a
//  rising-edge level trigger, fills one H_PIXELS-sample trace into a ping-pong buffer, and swaps
//  banks only at frame start. Serves the displayed bank to the pixel discriminator via pixel_x -> pixel_value.
// PARAMETERS
//  H_PIXELS      800   samples per trace = visible columns
//  SAMPLE_W      12    ADC sample width
//  ADDR_W        10    buffer address / pixel_x width (2**ADDR_W >= H_PIXELS)
//  DECIM_W       8     width of decimation ratio port
//  AUTO_TIMEOUT  4096  accepted samples without trigger before forced capture (AUTO_TRIG_EN only)
// PORTS
//  clk           in   1         system clock; all logic rising-edge
//  rst_n         in   1         asynchronous active-low reset
//  sample_valid  in   1         sample qualifier, 1-cycle strobe
//  sample        in   SAMPLE_W  unsigned ADC sample
//  decim         in   DECIM_W   keep 1 of every decim+1 valid samples (0 = keep all)
//  trig_level    in   SAMPLE_W  unsigned trigger threshold
//  arm           in   1         level; 1 = keep capturing traces
//  frame_start   in   1         1-cycle pulse from VGA timing at start of vertical blank
//  pixel_x       in   ADDR_W    display column being read
//  pixel_value   out  SAMPLE_W  stored sample for pixel_x, registered
//  trig_seen     out  1         1-cycle pulse on trigger (real or forced)
//  capturing     out  1         1 while state = CAPTURE
//  trace_valid   out  1         1 once a first completed trace has been swapped in
// BEHAVIOUR
//  Reset: state=IDLE, decim_cnt=0, wr_addr=0, disp_bank=0, prev_sample=0, all outputs 0.
//   Buffer RAM not cleared; trace_valid=0 forces pixel_value=0.
//  Accepted sample (acc): sample_valid & decim_cnt==decim. decim_cnt resets to 0 on acc, else +1 on valid.
//   Decimation runs in every state. decim changed mid-run: if decim_cnt>decim, counter resets to 0 on next valid.
//  prev_sample updates on every acc.
//  Trigger: acc & prev_sample < trig_level & sample >= trig_level. Unsigned compare.
//  FSM:
//   IDLE      -> WAIT_TRIG when arm=1.
//   WAIT_TRIG -> IDLE when arm=0, regardless of trigger that cycle.
//              -> CAPTURE on trigger. Trigger sample written to addr 0, wr_addr=1, trig_seen=1.
//   CAPTURE   : each acc writes to capture bank (~disp_bank) at wr_addr, wr_addr+1.
//              Write at H_PIXELS-1 -> DONE, wr_addr=0. arm=0 does not abort CAPTURE.
//   DONE      : no writes. On frame_start: disp_bank toggles, trace_valid=1,
//              next state WAIT_TRIG if arm=1, else IDLE.
//  frame_start in the same cycle as the last CAPTURE write does not swap; swap waits for the next frame_start.
//  frame_start in any state other than DONE has no effect. A bank is never written while displayed.
//  Read port: pixel_value <= (trace_valid & pixel_x<H_PIXELS) ? mem[disp_bank][pixel_x] : 0.
//   1-cycle latency. Read uses disp_bank as registered; the swap takes effect for reads the cycle after frame_start.
//  Async reset mid-CAPTURE: returns to IDLE immediately; the partial trace is discarded (trace_valid=0).
//  Memory: 2*H_PIXELS x SAMPLE_W, 1 write + 1 read port, inferable as block RAM.
// CONFIGURATION
//  AUTO_TRIG_EN defined:
//   - WAIT_TRIG counts acc samples; reaching AUTO_TIMEOUT forces a trigger on that acc (trig_seen=1).
//   - Counter clears on entry to WAIT_TRIG.
//   - A real trigger on the timeout cycle is treated as one trigger.
//  AUTO_TRIG_EN undefined: no timeout counter; WAIT_TRIG waits indefinitely (normal mode).
// TESTING
//  1 Reset, arm=1, decim=0, ramp 0..4095 step 8, trig_level=2048 -> trig_seen at sample 2048;
//    after DONE+frame_start, pixel_value(x)=2048+8x (mod 4096 wrap of ramp), trace_valid=1.
//  2 decim=3, constant-rate ramp -> stored trace step = 4x input step; addr 799 holds 3196 samples after trigger.
//  3 Falling ramp 4095->0, trig_level=2048 -> no trigger, capturing stays 0.
//    With AUTO_TRIG_EN: forced trigger after 4096 acc samples.
//  4 frame_start on the same cycle as the last CAPTURE write -> no swap; swap on the next pulse;
//    old trace readable until then.
//  5 arm=0 during CAPTURE at wr_addr=400 -> trace completes, swaps on frame_start, FSM ends in IDLE.
//    arm=0 in WAIT_TRIG -> IDLE next cycle.
//  6 rst_n low at wr_addr=500 -> state IDLE, trace_valid=0, pixel_value=0; pixel_x=820 always reads 0.

Source files
------------

// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: decimates the ADC stream and fires a rising-edge level trigger.
// It captures one H_PIXELS-sample trace into the hidden half of a ping-pong buffer.
// Banks swap only on frame_start, so the displayed bank is never rewritten mid-frame.
// Optional feature: define AUTO_TRIG_EN to force a trigger after AUTO_TIMEOUT
// accepted samples spent waiting in WAIT_TRIG.
module trace_capture_ctrl #(
   parameter int H_PIXELS     = 800,
   parameter int SAMPLE_W     = 12,
   parameter int ADDR_W       = 10,
   parameter int DECIM_W      = 8,
   parameter int AUTO_TIMEOUT = 4096
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [DECIM_W-1:0]  decim,
   input  logic [SAMPLE_W-1:0] trig_level,
   input  logic                arm,
   input  logic                frame_start,
   input  logic [ADDR_W-1:0]   pixel_x,
   output logic [SAMPLE_W-1:0] pixel_value,
   output logic                trig_seen,
   output logic                capturing,
   output logic                trace_valid
);

   typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

   // Bank 0 occupies [0, H_PIXELS), bank 1 occupies [H_PIXELS, 2*H_PIXELS).
   localparam int IDX_W     = ADDR_W + 1;
   localparam int MEM_DEPTH = 2 * H_PIXELS;

   state_t              state, state_next;
   logic [DECIM_W-1:0]  decim_cnt;
   logic [ADDR_W-1:0]   wr_addr, wr_addr_next, we_addr;
   logic                disp_bank, disp_bank_next, trace_valid_next;
   logic [SAMPLE_W-1:0] prev_sample;
   logic                acc, trig, trig_any, trig_fire, we;
   logic [IDX_W-1:0]    wr_idx, rd_idx;
   logic                rd_ok, rd_in_range;
   logic [SAMPLE_W-1:0] rd_data;
   logic [SAMPLE_W-1:0] mem [MEM_DEPTH];

   assign acc  = sample_valid && (decim_cnt == decim);
   assign trig = acc && (prev_sample < trig_level) && (sample >= trig_level);

`ifdef AUTO_TRIG_EN
   localparam int AUTO_W = $clog2(AUTO_TIMEOUT) + 1;
   logic [AUTO_W-1:0] auto_cnt;
   logic              auto_fire;

   assign auto_fire = acc && (auto_cnt == AUTO_W'(AUTO_TIMEOUT - 1));

   // Timeout counter: held at zero outside WAIT_TRIG so every entry starts fresh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  auto_cnt <= '0;
      else if (state != WAIT_TRIG) auto_cnt <= '0;
      else if (acc)                auto_cnt <= auto_cnt + AUTO_W'(1);
   end

   // A real trigger coinciding with the timeout collapses into one trigger.
   assign trig_any = trig || auto_fire;
`else
   assign trig_any = trig;
`endif

   // Decimation counter and previous accepted sample, running in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         decim_cnt   <= '0;
         prev_sample <= '0;
      end else if (sample_valid) begin
         // >= also recovers when decim is lowered below the current count.
         if (decim_cnt >= decim) decim_cnt <= '0;
         else                    decim_cnt <= decim_cnt + DECIM_W'(1);
         if (acc) prev_sample <= sample;
      end
   end

   // Capture FSM: next state, write strobe and bank swap.
   always_comb begin
      state_next       = state;
      wr_addr_next     = wr_addr;
      disp_bank_next   = disp_bank;
      trace_valid_next = trace_valid;
      trig_fire        = 1'b0;
      we               = 1'b0;
      we_addr          = wr_addr;
      case (state)
         IDLE: begin
            if (arm) state_next = WAIT_TRIG;
         end
         WAIT_TRIG: begin
            if (!arm) begin
               state_next = IDLE;
            end else if (trig_any) begin
               trig_fire    = 1'b1;
               we           = 1'b1;
               we_addr      = '0;
               wr_addr_next = ADDR_W'(1);
               state_next   = CAPTURE;
            end
         end
         CAPTURE: begin
            if (acc) begin
               we = 1'b1;
               if (wr_addr == ADDR_W'(H_PIXELS - 1)) begin
                  wr_addr_next = '0;
                  state_next   = DONE;
               end else begin
                  wr_addr_next = wr_addr + ADDR_W'(1);
               end
            end
         end
         DONE: begin
            if (frame_start) begin
               disp_bank_next   = ~disp_bank;
               trace_valid_next = 1'b1;
               state_next       = arm ? WAIT_TRIG : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wr_addr     <= '0;
         disp_bank   <= 1'b0;
         trace_valid <= 1'b0;
         trig_seen   <= 1'b0;
      end else begin
         state       <= state_next;
         wr_addr     <= wr_addr_next;
         disp_bank   <= disp_bank_next;
         trace_valid <= trace_valid_next;
         trig_seen   <= trig_fire;
      end
   end

   assign capturing = (state == CAPTURE);

   // Writes go to the hidden bank; reads come from the displayed bank.
   // Out-of-range columns are clamped to a legal index and masked below.
   always_comb begin
      wr_idx      = {1'b0, we_addr} + (disp_bank ? IDX_W'(0) : IDX_W'(H_PIXELS));
      rd_in_range = trace_valid && (pixel_x < ADDR_W'(H_PIXELS));
      rd_idx      = '0;
      if (rd_in_range)
         rd_idx = {1'b0, pixel_x} + (disp_bank ? IDX_W'(H_PIXELS) : IDX_W'(0));
   end

   // Buffer RAM: one write port and one registered read port, kept reset-free.
   always_ff @(posedge clk) begin
      if (we) mem[wr_idx] <= sample;
      rd_data <= mem[rd_idx];
   end

   // Read qualifier: resettable, so pixel_value drops to zero on reset or when invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_ok <= 1'b0;
      else        rd_ok <= rd_in_range;
   end

   assign pixel_value = rd_ok ? rd_data : '0;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed testbench for trace_capture_ctrl (default build, AUTO_TRIG_EN undefined).
module tb_trace_capture_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [11:0] sample = '0;
   logic [7:0]  decim = '0;
   logic [11:0] trig_level = '0;
   logic        arm = 1'b0;
   logic        frame_start = 1'b0;
   logic [9:0]  pixel_x = '0;
   logic [11:0] pixel_value;
   logic        trig_seen, capturing, trace_valid;

   int total = 0;
   int bad   = 0;

   trace_capture_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample       (sample),
      .decim        (decim),
      .trig_level   (trig_level),
      .arm          (arm),
      .frame_start  (frame_start),
      .pixel_x      (pixel_x),
      .pixel_value  (pixel_value),
      .trig_seen    (trig_seen),
      .capturing    (capturing),
      .trace_valid  (trace_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [11:0] v);
      sample       = v;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic rd(input int x, input int exp, input string tag);
      pixel_x = 10'(x);
      tick();
      chk(tag, 32'(pixel_value), 32'(exp));
      $display("read %s x=%0d value=%0d", tag, x, pixel_value);
   endtask

   initial begin
      logic seen;

      // Reset state
      arm        = 1'b1;
      decim      = 8'd0;
      trig_level = 12'd2048;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pixel_value", 32'(pixel_value), 0);
      chk("rst_trace_valid", 32'(trace_valid), 0);
      chk("rst_capturing",   32'(capturing),   0);
      chk("rst_trig_seen",   32'(trig_seen),   0);
      rst_n = 1'b1;

      // Test 1: rising ramp step 8, decim=0
      for (int k = 0; k < 256; k++) send(12'(8 * k));
      chk("t1_pre_trig_seen", 32'(trig_seen), 0);
      chk("t1_pre_capturing", 32'(capturing), 0);
      send(12'd2048);
      chk("t1_trig_seen", 32'(trig_seen), 1);
      chk("t1_capturing", 32'(capturing), 1);
      for (int k = 257; k < 1055; k++) send(12'(8 * k));
      chk("t1_still_capturing", 32'(capturing), 1);
      chk("t1_trig_pulse_ended", 32'(trig_seen), 0);
      send(12'(8 * 1055));
      chk("t1_done_capturing", 32'(capturing), 0);
      chk("t1_no_valid_yet", 32'(trace_valid), 0);
      rd(0, 0, "t1_read_before_swap");
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("t1_trace_valid", 32'(trace_valid), 1);
      rd(0,   2048, "t1_x0");
      rd(1,   2056, "t1_x1");
      rd(255, 4088, "t1_x255");
      rd(256, 0,    "t1_x256_wrap");
      rd(799, 248,  "t1_x799");
      rd(820, 0,    "t1_x820");

      // Tests 2, 4, 5: decim=3, arm dropped at wr_addr=400, frame_start on the last write
      decim = 8'd3;
      for (int j = 0; j < 4224; j++) begin
         sample       = 12'(2 * j);
         sample_valid = 1'b1;
         frame_start  = (j == 4223);
         if (j == 2624) arm = 1'b0;
         tick();
         if (j == 1027) chk("t2_trig_seen", 32'(trig_seen), 1);
         if (j == 3000) chk("t5_capture_continues", 32'(capturing), 1);
      end
      sample_valid = 1'b0;
      frame_start  = 1'b0;
      chk("t4_done_capturing", 32'(capturing), 0);
      rd(0,   2048, "t4_old_x0");
      rd(799, 248,  "t4_old_x799");
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      rd(0,   2054, "t2_x0");
      rd(256, 6,    "t2_x256");
      rd(799, 254,  "t2_x799");

      // Test 3 and WAIT_TRIG disarm: falling ramp, then arm=0 with a triggering sample
      decim = 8'd0;
      send(12'd4095);
      chk("t5_idle_no_trig", 32'(trig_seen), 0);
      arm = 1'b1;
      tick();
      seen = 1'b0;
      for (int k = 0; k < 256; k++) begin
         send(12'(4095 - 16 * k));
         seen = seen | trig_seen | capturing;
      end
      chk("t3_falling_no_trig", 32'(seen), 0);
      arm = 1'b0;
      send(12'd3000);
      chk("t5_disarm_trig_seen", 32'(trig_seen), 0);
      chk("t5_disarm_capturing", 32'(capturing), 0);
      send(12'd0);
      send(12'd3000);
      chk("t5_idle_trig_seen", 32'(trig_seen), 0);

      // Test 6: reset in the middle of a capture
      arm = 1'b1;
      tick();
      send(12'd0);
      send(12'd2048);
      chk("t6_trig_seen", 32'(trig_seen), 1);
      for (int i = 1; i < 500; i++) send(12'(i));
      chk("t6_capturing", 32'(capturing), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_capturing",   32'(capturing),   0);
      chk("t6_rst_trace_valid", 32'(trace_valid), 0);
      chk("t6_rst_pixel_value", 32'(pixel_value), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd(0,   0, "t6_x0_after_rst");
      rd(820, 0, "t6_x820_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
